// File: rtl/sha256_stream_core.sv
// SHA-256 compression engine: valid/ready block in, digest out, 1/2/4 rounds per clock.
// Chaining value H persists across blocks and messages until blk_first overrides it.
module sha256_stream_core #(
  parameter int UNROLL = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [15:0][31:0] blk_data,
  input  logic              blk_first,
  input  logic              iv_load,
  input  logic [7:0][31:0]  iv_in,
  input  logic              blk_last,
  output logic              dig_valid,
  input  logic              dig_ready,
  output logic [7:0][31:0]  dig_data,
  output logic              busy
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("sha256_stream_core: UNROLL must be 1, 2 or 4");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // blk_ready depends only on state, and dig_valid holds with stable dig_data until taken.

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FINAL, S_OUT} state_t;

  localparam logic [5:0] T_LAST = 6'(64 - UNROLL);

  // Element [0] is H0, so the concatenation lists H7 first.
  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    bsig0 = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    bsig1 = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    ssig0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    ssig1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t           state_q, state_d;
  logic [7:0][31:0] h_q, v_q, v_d, h_sum, cv, dig_q;
  logic [15:0][31:0] w_q, w_d;
  logic [5:0]       t_q;
  logic             last_q;
  logic [31:0]      t1, t2, wnew;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (blk_valid)     state_d = S_COMPUTE;
      S_COMPUTE: if (t_q == T_LAST) state_d = S_FINAL;
      S_FINAL:   state_d = last_q ? S_OUT : S_IDLE;
      S_OUT:     if (dig_ready)     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    blk_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    dig_valid = (state_q == S_OUT);
  end

  assign dig_data = dig_q;

  always_comb begin
    cv = h_q;
    if (blk_first) cv = iv_load ? iv_in : IV;
  end

  // UNROLL chained rounds; the schedule window slides one word per round.
  always_comb begin
    v_d  = v_q;
    w_d  = w_q;
    t1   = '0;
    t2   = '0;
    wnew = '0;
    for (int i = 0; i < UNROLL; i++) begin
      t1   = v_d[7] + bsig1(v_d[4]) + ((v_d[4] & v_d[5]) ^ (~v_d[4] & v_d[6]))
             + K[t_q + 6'(i)] + w_d[0];
      t2   = bsig0(v_d[0]) + ((v_d[0] & v_d[1]) ^ (v_d[0] & v_d[2]) ^ (v_d[1] & v_d[2]));
      wnew = w_d[0] + ssig0(w_d[1]) + w_d[9] + ssig1(w_d[14]);
      v_d  = {v_d[6], v_d[5], v_d[4], v_d[3] + t1, v_d[2], v_d[1], v_d[0], t1 + t2};
      w_d  = {wnew, w_d[15:1]};
    end
  end

  always_comb begin
    h_sum = '0;
    for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + v_q[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q    <= IV;
      v_q    <= '0;
      w_q    <= '0;
      t_q    <= '0;
      last_q <= 1'b0;
      dig_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (blk_valid) begin
          w_q    <= blk_data;
          h_q    <= cv;
          v_q    <= cv;
          last_q <= blk_last;
          t_q    <= '0;
        end
        S_COMPUTE: begin
          w_q <= w_d;
          v_q <= v_d;
          t_q <= t_q + 6'(UNROLL);
        end
        S_FINAL: begin
          h_q <= h_sum;
          if (last_q) dig_q <= h_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Bench for sha256_stream_core: one instance per UNROLL value (1, 2, 4), shared block bus,
// expected digests queued at accept and compared when each digest is taken.
module tb_sha256_stream_core;

  localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
    32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] IV_FLAT   = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]        valid_v, dready_v;
  wire  [2:0]        ready_v, dvalid_v, busy_v;
  wire  [255:0]      ddata_v [3];
  logic [15:0][31:0] blk_data;
  logic              blk_first, iv_load, blk_last;
  logic [7:0][31:0]  iv_in;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sha256_stream_core #(.UNROLL(1 << g)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .blk_valid (valid_v[g]),
      .blk_ready (ready_v[g]),
      .blk_data  (blk_data),
      .blk_first (blk_first),
      .iv_load   (iv_load),
      .iv_in     (iv_in),
      .blk_last  (blk_last),
      .dig_valid (dvalid_v[g]),
      .dig_ready (dready_v[g]),
      .dig_data  (ddata_v[g]),
      .busy      (busy_v[g])
    );
  end

  // ---------------- checking / reference model ----------------
  int total = 0;
  int bad   = 0;
  logic [255:0] exp_q[$];
  logic [255:0] last_dig;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight textbook SHA-256 compression with a fully expanded 64-word schedule.
  function automatic logic [255:0] sha_model(input logic [255:0] cv, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s1, ch, tt1, s0, mj;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr32(w[i-2], 17) ^ rr32(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr32(w[i-15], 7) ^ rr32(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = cv[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      s1  = rr32(v[4], 6) ^ rr32(v[4], 11) ^ rr32(v[4], 25);
      ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
      tt1 = v[7] + s1 + ch + KT[i] + w[i];
      s0  = rr32(v[0], 2) ^ rr32(v[0], 13) ^ rr32(v[0], 22);
      mj  = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + tt1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = tt1 + s0 + mj;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = cv[255-32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [15:0][31:0] to_blk(input logic [511:0] b);
    logic [15:0][31:0] r;
    for (int i = 0; i < 16; i++) r[i] = b[511-32*i -: 32];
    return r;
  endfunction

  function automatic logic [7:0][31:0] to_iv(input logic [255:0] v);
    logic [7:0][31:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[255-32*i -: 32];
    return r;
  endfunction

  function automatic logic [255:0] from_dig(input logic [255:0] d);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = d[32*i +: 32];
    return r;
  endfunction

  // Scoreboard: a digest is taken on the edge after a low-phase sample of valid & ready.
  logic [255:0] mon_got, mon_exp;
  always begin
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (dvalid_v[k] && dready_v[k]) begin
        check("sb_has_exp", 256'(exp_q.size() != 0), 256'(1));
        if (exp_q.size() != 0) begin
          mon_exp  = exp_q.pop_front();
          mon_got  = from_dig(ddata_v[k]);
          last_dig = mon_got;
          check("digest", mon_got, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the accepting rising edge
  // with blk_valid still high. acc is the cycle number of the accepting edge.
  task automatic send_block(input int k, input logic [511:0] b, input logic first,
                            input logic ivl, input logic [255:0] iv, input logic last,
                            input logic push, input logic [255:0] e, output int acc);
    int n = 0;
    blk_data   = to_blk(b);
    blk_first  = first;
    iv_load    = ivl;
    iv_in      = to_iv(iv);
    blk_last   = last;
    valid_v[k] = 1'b1;
    while (!ready_v[k] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("acc_ready", 256'(ready_v[k]), 256'(1));
    acc = cyc + 1;
    if (push) exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (!ready_v[k] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle", 256'(ready_v[k]), 256'(1));
  endtask

  task automatic wait_dig(input int k, output int at);
    int n = 0;
    while (!dvalid_v[k] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("dig_seen", 256'(dvalid_v[k]), 256'(1));
    at = cyc;
  endtask

  task automatic check_reset_state(input int k);
    check("rst_ready", 256'(ready_v[k]), 256'(1));
    check("rst_busy",  256'(busy_v[k]),  256'(0));
    check("rst_dval",  256'(dvalid_v[k]), 256'(0));
    check("rst_ddata", ddata_v[k], 256'(0));
  endtask

  task automatic run_suite(input int k);
    int rr, a1, a2, at;
    logic [511:0] rb;
    logic [255:0] riv, cv, cv_m;
    logic first, ivl, last;
    rr = 64 >> k;

    // "abc" single block and its latency
    send_block(k, ABC, 1'b1, 1'b0, '0, 1'b1, 1'b1, ABC_DIG, a1);
    valid_v[k] = 1'b0;
    wait_dig(k, at);
    check("abc_latency", 256'(at - a1), 256'(rr + 1));
    wait_idle(k);

    // two-block message, valid held between blocks
    send_block(k, B1, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, a1);
    send_block(k, B2, 1'b0, 1'b0, '0, 1'b1, 1'b1, TWO_DIG, a2);
    valid_v[k] = 1'b0;
    check("blk_period", 256'(a2 - a1), 256'(rr + 2));
    wait_idle(k);

    // midstate capture, disturb H with "abc", then resume via iv_load
    send_block(k, B1, 1'b1, 1'b0, '0, 1'b1, 1'b1, sha_model(IV_FLAT, B1), a1);
    valid_v[k] = 1'b0;
    wait_idle(k);
    riv = last_dig;
    send_block(k, ABC, 1'b1, 1'b0, '0, 1'b1, 1'b1, ABC_DIG, a1);
    valid_v[k] = 1'b0;
    wait_idle(k);
    send_block(k, B2, 1'b1, 1'b1, riv, 1'b1, 1'b1, TWO_DIG, a1);
    valid_v[k] = 1'b0;
    wait_idle(k);

    // digest backpressure with a competing block offered during the stall
    dready_v[k] = 1'b0;
    send_block(k, EMPTY, 1'b1, 1'b0, '0, 1'b1, 1'b1, EMPTY_DIG, a1);
    valid_v[k] = 1'b0;
    wait_dig(k, at);
    blk_data   = to_blk(ABC);
    blk_first  = 1'b1;
    blk_last   = 1'b1;
    valid_v[k] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold",  from_dig(ddata_v[k]), EMPTY_DIG);
      check("bp_ready", 256'(ready_v[k]), 256'(0));
      @(negedge clk);
    end
    valid_v[k]  = 1'b0;
    dready_v[k] = 1'b1;
    wait_idle(k);

    // asynchronous reset around round 30, then blk_first=0 must chain from the reset IV
    send_block(k, EMPTY, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, a1);
    valid_v[k] = 1'b0;
    repeat (30 / (1 << k)) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_state(k);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_block(k, ABC, 1'b0, 1'b0, '0, 1'b1, 1'b1, ABC_DIG, a1);
    valid_v[k] = 1'b0;
    wait_idle(k);

    // back-to-back messages with valid held high
    send_block(k, ABC, 1'b1, 1'b0, '0, 1'b1, 1'b1, ABC_DIG, a1);
    send_block(k, EMPTY, 1'b1, 1'b0, '0, 1'b1, 1'b1, EMPTY_DIG, a2);
    valid_v[k] = 1'b0;
    check("msg_period", 256'(a2 - a1), 256'(rr + 3));
    wait_idle(k);

    // random chained blocks, including chaining across message boundaries
    cv_m = IV_FLAT;
    for (int n = 0; n < 5; n++) begin
      for (int j = 0; j < 16; j++) rb[511-32*j -: 32] = $urandom;
      for (int j = 0; j < 8; j++) riv[255-32*j -: 32] = $urandom;
      first = (n == 0) || ($urandom_range(0, 2) == 0);
      ivl   = 1'($urandom_range(0, 1));
      last  = (n == 4) || ($urandom_range(0, 1) == 1);
      cv    = first ? (ivl ? riv : IV_FLAT) : cv_m;
      cv_m  = sha_model(cv, rb);
      send_block(k, rb, first, ivl, riv, last, last, cv_m, a1);
      valid_v[k] = 1'b0;
    end
    wait_idle(k);
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    int n;
    reset_n   = 1'b0;
    valid_v   = '0;
    dready_v  = '1;
    blk_data  = '0;
    blk_first = 1'b0;
    iv_load   = 1'b0;
    blk_last  = 1'b0;
    iv_in     = '0;
    last_dig  = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check_reset_state(k);
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) run_suite(k);
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", 256'(exp_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
